serial_lut_loader: RTL and testbench

Initiator side of the serial LUT programming interface. It takes table entries from a host through a valid/ready handshake and generates the LUT serial pins. Those pins are lut_d, lut_clk, lut_cs_n and lut_rot_n. Each entry is shifted MSB-first with chip select held low for the whole frame. On request the block also issues single rotate strobes. It sits between the on-chip controller and the serial-load LUT, and drives that LUT's d/clk/cs_n/rot_n pins.

---
 rtl/serial_lut_pkg.sv | 31 +++
 rtl/lut_clk_phase_timer.sv | 33 +++
 rtl/serial_lut_loader.sv | 150 +++++++++++++++
 tb/tb_serial_lut_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_lut_pkg.sv
// Shared definitions for the serial LUT loader.
// Contents:
//   state_t      - loader FSM states
//   lut_entries  - number of LUT words for a given select width
//   frame_cycles - system clocks from first word accept to the done cycle of a
//                  full frame when the host never stalls
package serial_lut_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_BIT_LO,
    S_BIT_HI,
    S_ROT_LO,
    S_ROT_HI,
    S_END
  } state_t;

  function automatic int lut_entries(input int in_width);
    return 1 << in_width;
  endfunction

  // Each word costs one accept cycle plus OUT_WIDTH full lut_clk periods.
  function automatic int frame_cycles(input int in_width, input int out_width,
                                      input int half_period);
    return lut_entries(in_width) * (1 + 2 * half_period * out_width);
  endfunction

  localparam int DEFAULT_ENTRIES = lut_entries(4);

endpackage

// File: rtl/lut_clk_phase_timer.sv
// Half-period timer for the generated LUT clock.
// Ports:
//   clk, rst_n - system clock, asynchronous active-low reset
//   i_load     - restart the timer for a new low or high phase
//   o_term     - high during the last system clock of the current phase
module lut_clk_phase_timer #(
  parameter int HALF_PERIOD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_term
);

  localparam int CW = $clog2(HALF_PERIOD + 1);

  logic [CW-1:0] r_cnt;

  // Loading HALF_PERIOD-1 makes the phase last exactly HALF_PERIOD cycles,
  // with the terminal flag raised in its final cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(HALF_PERIOD - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_term = (r_cnt == '0);

endmodule

// File: rtl/serial_lut_loader.sv
// Initiator for the serial-load LUT: accepts table words from a host over a
// valid/ready handshake and shifts them MSB-first into the LUT, or issues a
// single rotate strobe on request.
// Ports:
//   clk, rst_n            - system clock, asynchronous active-low reset
//   word_valid/word_ready - host handshake, transfer when both high
//   word_data             - table entry (OUT_WIDTH bits)
//   rot_req               - request one rotate strobe (sampled in IDLE only)
//   busy                  - high whenever the loader is not idle
//   done                  - one-cycle pulse at end of frame or rotate
//   lut_d/lut_clk/lut_cs_n/lut_rot_n - registered LUT serial pins
module serial_lut_loader
  import serial_lut_pkg::*;
#(
  parameter int IN_WIDTH    = 4,
  parameter int OUT_WIDTH   = 3,
  parameter int HALF_PERIOD = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 word_valid,
  output logic                 word_ready,
  input  logic [OUT_WIDTH-1:0] word_data,
  input  logic                 rot_req,
  output logic                 busy,
  output logic                 done,
  output logic                 lut_d,
  output logic                 lut_clk,
  output logic                 lut_cs_n,
  output logic                 lut_rot_n
);

  localparam int ENTRIES = lut_entries(IN_WIDTH);
  localparam int BW      = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
  localparam logic [BW-1:0]       BIT_TOP  = BW'(OUT_WIDTH - 1);
  localparam logic [IN_WIDTH-1:0] WORD_TOP = IN_WIDTH'(ENTRIES - 1);

  state_t               r_state, w_state_nxt;
  logic [OUT_WIDTH-1:0] r_word, w_word_nxt;
  logic [BW-1:0]        r_bit_cnt, w_bit_nxt;
  logic [IN_WIDTH-1:0]  r_word_cnt, w_wcnt_nxt;
  logic                 w_term;
  logic                 w_load;
  logic                 w_d_nxt;

  logic r_word_ready, r_busy, r_done, r_lut_d, r_lut_clk, r_lut_cs_n, r_lut_rot_n;

  // Every LO/HI phase starts on a state change, so one restart covers them all.
  assign w_load = (w_state_nxt != r_state);

  lut_clk_phase_timer #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_phase (
    .clk   (clk),
    .rst_n (rst_n),
    .i_load(w_load),
    .o_term(w_term)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_bit_nxt   = r_bit_cnt;
    w_wcnt_nxt  = r_word_cnt;
    case (r_state)
      S_IDLE: begin
        // A word offer wins over a rotate request.
        if (word_valid) begin
          w_word_nxt  = word_data;
          w_bit_nxt   = BIT_TOP;
          w_wcnt_nxt  = '0;
          w_state_nxt = S_BIT_LO;
        end else if (rot_req) begin
          w_state_nxt = S_ROT_LO;
        end
      end
      S_FETCH: begin
        // Waiting here is harmless: the LUT only acts on lut_clk rising edges.
        if (word_valid) begin
          w_word_nxt  = word_data;
          w_bit_nxt   = BIT_TOP;
          w_wcnt_nxt  = r_word_cnt + 1'b1;
          w_state_nxt = S_BIT_LO;
        end
      end
      S_BIT_LO: if (w_term) w_state_nxt = S_BIT_HI;
      S_BIT_HI: begin
        if (w_term) begin
          if (r_bit_cnt != '0) begin
            w_bit_nxt   = r_bit_cnt - 1'b1;
            w_state_nxt = S_BIT_LO;
          end else if (r_word_cnt != WORD_TOP) begin
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_END;
          end
        end
      end
      S_ROT_LO: if (w_term) w_state_nxt = S_ROT_HI;
      S_ROT_HI: if (w_term) w_state_nxt = S_END;
      S_END:    w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // New data bit is presented only when a low phase begins, so lut_d is
  // stable through the whole high phase.
  assign w_d_nxt = (w_state_nxt == S_BIT_LO) ? w_word_nxt[w_bit_nxt] : r_lut_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_word_cnt   <= '0;
      r_word_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_lut_d      <= 1'b0;
      r_lut_clk    <= 1'b0;
      r_lut_cs_n   <= 1'b1;
      r_lut_rot_n  <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_nxt;
      r_word_cnt   <= w_wcnt_nxt;
      // Pins are registered from the next state so they line up with r_state.
      r_word_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_FETCH);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_done       <= (w_state_nxt == S_END);
      r_lut_d      <= w_d_nxt;
      r_lut_clk    <= (w_state_nxt == S_BIT_HI) || (w_state_nxt == S_ROT_HI);
      r_lut_cs_n   <= !((w_state_nxt == S_BIT_LO) || (w_state_nxt == S_BIT_HI) ||
                        (w_state_nxt == S_FETCH));
      r_lut_rot_n  <= !((w_state_nxt == S_ROT_LO) || (w_state_nxt == S_ROT_HI));
    end
  end

  always_ff @(posedge clk) begin
    r_word <= w_word_nxt;
  end

  assign word_ready = r_word_ready;
  assign busy       = r_busy;
  assign done       = r_done;
  assign lut_d      = r_lut_d;
  assign lut_clk    = r_lut_clk;
  assign lut_cs_n   = r_lut_cs_n;
  assign lut_rot_n  = r_lut_rot_n;

endmodule

// File: tb/tb_serial_lut_loader.sv
// Bench for serial_lut_loader with default parameters, including a behavioural
// model of the serial-load LUT attached to the generated pins.
module tb_serial_lut_loader;

  localparam int IW = 4;
  localparam int OW = 3;
  localparam int HP = 2;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          word_valid = 1'b0;
  logic          rot_req = 1'b0;
  logic [OW-1:0] word_data = '0;
  logic          word_ready, busy, done, lut_d, lut_clk, lut_cs_n, lut_rot_n;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_lut_loader #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .HALF_PERIOD(HP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .word_valid(word_valid), .word_ready(word_ready),
    .word_data(word_data), .rot_req(rot_req), .busy(busy), .done(done),
    .lut_d(lut_d), .lut_clk(lut_clk), .lut_cs_n(lut_cs_n), .lut_rot_n(lut_rot_n)
  );

  // LUT model: one long chain, new bit enters at the bottom of entry 0.
  logic [N*OW-1:0] chain = '0;
  logic            edge_d [0:1023];
  int cs_edges = 0, rot_edges = 0, rot_clash = 0;

  always @(posedge lut_clk) begin
    if (!lut_cs_n) begin
      if (cs_edges < 1024) edge_d[cs_edges] = lut_d;
      cs_edges++;
      chain = {chain[N*OW-2:0], lut_d};
    end
    if (!lut_rot_n) begin
      rot_edges++;
      if (!lut_cs_n) rot_clash++;
      chain = {chain[OW-1:0], chain[N*OW-1:OW]};
    end
  end

  // Pin-change watcher: d/cs_n/rot_n may only move while lut_clk is low.
  logic p_d = 1'b0, p_cs = 1'b1, p_rot = 1'b1;
  int viol = 0, rot_low = 0;
  always @(negedge clk) begin
    if (rst_n && lut_clk && (lut_d != p_d || lut_cs_n != p_cs || lut_rot_n != p_rot))
      viol++;
    if (!lut_rot_n) rot_low++;
    p_d = lut_d; p_cs = lut_cs_n; p_rot = lut_rot_n;
  end

  function automatic int lut_read(input int sel);
    return int'(chain[sel*OW +: OW]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic [OW-1:0] fw [N];

  // Called at a negedge. Offers fw[] in order; optionally holds word_valid low
  // for stall_len FETCH cycles after stall_at words. cyc = negedges from the
  // accept sample of word 0 to the first sample with done high (-1 on timeout).
  task automatic run_frame(input int stall_at, input int stall_len,
                           output int cyc, output int stall_bad);
    int idx = 0, rem = 0, c = 0;
    bit started = 0;
    cyc = -1;
    stall_bad = 0;
    for (int t = 0; t < 1000; t++) begin
      if (started) begin
        c++;
        if (done) begin
          cyc = c;
          break;
        end
      end
      if (rem > 0) begin
        word_valid = 1'b0;
        if (word_ready) begin
          if (lut_clk !== 1'b0 || lut_cs_n !== 1'b0) stall_bad++;
          rem--;
        end
      end else if (idx < N) begin
        word_valid = 1'b1;
        word_data  = fw[idx];
        if (word_ready) begin
          started = 1;
          idx++;
          if (idx == stall_at) rem = stall_len;
        end
      end else begin
        word_valid = 1'b0;
      end
      @(negedge clk);
    end
    word_valid = 1'b0;
  endtask

  typedef struct {
    logic [OW-1:0] w0;
    int            e0;
    int            e1;
    int            e2;
  } bo_t;

  typedef struct {
    int sel;
    int exp;
  } rb_t;

  bo_t bo_tab [4];
  rb_t rb_plain [5];
  rb_t rb_rot [5];

  initial begin
    int cyc, sbad, base, rbase, lbase, c;

    bo_tab[0] = '{3'b101, 1, 0, 1};
    bo_tab[1] = '{3'b110, 1, 1, 0};
    bo_tab[2] = '{3'b011, 0, 1, 1};
    bo_tab[3] = '{3'b111, 1, 1, 1};
    // After a frame of words (15-j)&7: entry k holds k&7.
    rb_plain[0] = '{15, 7};
    rb_plain[1] = '{0, 0};
    rb_plain[2] = '{9, 1};
    rb_plain[3] = '{4, 4};
    rb_plain[4] = '{8, 0};
    // After one rotate: sel=k reads former entry (k+1) mod 16.
    rb_rot[0] = '{3, 4};
    rb_rot[1] = '{15, 0};
    rb_rot[2] = '{7, 0};
    rb_rot[3] = '{0, 1};
    rb_rot[4] = '{14, 7};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst word_ready", int'(word_ready), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst lut_clk", int'(lut_clk), 0);
    chk("rst lut_cs_n", int'(lut_cs_n), 1);
    chk("rst lut_rot_n", int'(lut_rot_n), 1);
    chk("rst lut_d", int'(lut_d), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle word_ready", int'(word_ready), 1);
    chk("idle busy", int'(busy), 0);

    // Full frames, first word varied; the last one is the default 7,6,..,0 frame
    for (int r = 0; r < 4; r++) begin
      fw[0] = bo_tab[r].w0;
      for (int j = 1; j < N; j++) fw[j] = OW'((15 - j) & 7);
      base = cs_edges;
      run_frame(0, 0, cyc, sbad);
      chk($sformatf("frame%0d done cycle", r), cyc, 208);
      chk($sformatf("frame%0d cs edges", r), cs_edges - base, 48);
      chk($sformatf("frame%0d bit0", r), int'(edge_d[base]), bo_tab[r].e0);
      chk($sformatf("frame%0d bit1", r), int'(edge_d[base+1]), bo_tab[r].e1);
      chk($sformatf("frame%0d bit2", r), int'(edge_d[base+2]), bo_tab[r].e2);
    end
    @(negedge clk);
    chk("done pulse width", int'(done), 0);
    for (int i = 0; i < 5; i++)
      chk($sformatf("readback sel%0d", rb_plain[i].sel), lut_read(rb_plain[i].sel), rb_plain[i].exp);

    // Rotate strobe
    base = cs_edges; rbase = rot_edges;
    rot_req = 1'b1; c = 0; cyc = -1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      c++;
      if (busy) rot_req = 1'b0;
      if (done) begin cyc = c; break; end
    end
    rot_req = 1'b0;
    chk("rotate done cycle", cyc, 5);
    chk("rotate edges", rot_edges - rbase, 1);
    chk("rotate cs edges", cs_edges - base, 0);
    chk("rotate cs_n high", rot_clash, 0);
    for (int i = 0; i < 5; i++)
      chk($sformatf("rot readback sel%0d", rb_rot[i].sel), lut_read(rb_rot[i].sel), rb_rot[i].exp);

    // Host stall of 10 cycles after word 4 (fifth transfer)
    @(negedge clk);
    for (int j = 0; j < N; j++) fw[j] = OW'((15 - j) & 7);
    base = cs_edges;
    run_frame(5, 10, cyc, sbad);
    chk("stall done cycle", cyc, 218);
    chk("stall cs edges", cs_edges - base, 48);
    chk("stall pins idle", sbad, 0);
    chk("stall readback sel15", lut_read(15), 7);

    // word_valid and rot_req together: frame first, rotate only after done
    base = cs_edges; rbase = rot_edges; lbase = rot_low;
    rot_req = 1'b1;
    run_frame(0, 0, cyc, sbad);
    chk("prio done cycle", cyc, 208);
    chk("prio cs edges", cs_edges - base, 48);
    chk("prio no rot during frame", rot_low - lbase, 0);
    chk("prio no rot edge during frame", rot_edges - rbase, 0);
    c = 0; cyc = -1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      c++;
      if (busy) rot_req = 1'b0;
      if (done) begin cyc = c; break; end
    end
    rot_req = 1'b0;
    chk("prio rotate done cycle", cyc, 6);
    chk("prio rotate edges", rot_edges - rbase, 1);

    // Reset in the middle of a high phase
    word_valid = 1'b1; word_data = 3'b101; c = -1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (lut_clk) begin c = t; break; end
    end
    chk("midreset reached high phase", int'(c >= 0), 1);
    #1 rst_n = 1'b0;
    word_valid = 1'b0;
    #1;
    chk("midreset lut_clk", int'(lut_clk), 0);
    chk("midreset lut_cs_n", int'(lut_cs_n), 1);
    chk("midreset busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post reset word_ready", int'(word_ready), 1);
    chk("post reset busy", int'(busy), 0);

    chk("pin change while lut_clk high", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
